// File: rtl/plane_loader.sv
// plane_loader: streams one plane of pixel intensities to a PWM plane
// receiver, framed by disable/address commands and a final enable.
module plane_loader #(
    parameter int OUT_NUM   = 64,
    parameter int D_WIDTH   = 8,
    parameter int C_WIDTH   = 5,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [C_WIDTH-1:0] pixData,
    input  logic               pixValid,
    output logic               pixReady,
    output logic [D_WIDTH-1:0] dataOut,
    output logic               dataEn,
    output logic               rs,
    output logic               busy,
    output logic               done
);
    localparam int TW = $clog2(PULSE_LEN + GAP_LEN + 1);
    localparam logic [TW-1:0] T_PULSE = TW'(PULSE_LEN);
    localparam logic [TW-1:0] T_LAST  = TW'(PULSE_LEN + GAP_LEN);
    localparam logic [6:0]    N_PIX   = 7'(OUT_NUM);

    localparam logic [D_WIDTH-1:0] C_OFF  = D_WIDTH'(8'h08);
    localparam logic [D_WIDTH-1:0] C_DIR  = D_WIDTH'(8'h06);
    localparam logic [D_WIDTH-1:0] C_ADDR = D_WIDTH'(8'h80);
    localparam logic [D_WIDTH-1:0] C_ON   = D_WIDTH'(8'h0C);

    typedef enum logic [2:0] {
        IDLE, CMD_OFF, CMD_DIR, CMD_ADDR,
        WAIT_PIX, DATA, CMD_ON, FIN
    } state_t;

    state_t             state;
    logic [TW-1:0]      tcnt;
    logic [6:0]         pix_cnt;
    logic [D_WIDTH-1:0] pix_ext;
    logic               xfer_last;

    always_comb begin
        pix_ext = '0;
        pix_ext[C_WIDTH-1:0] = pixData;
    end

    assign xfer_last = (tcnt == T_LAST);

    // tcnt 0 is the setup cycle; bus word for a state is loaded on entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tcnt     <= '0;
            pix_cnt  <= '0;
            dataOut  <= '0;
            dataEn   <= 1'b0;
            rs       <= 1'b0;
            pixReady <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        dataOut <= C_OFF;
                        rs      <= 1'b1;
                        tcnt    <= '0;
                        state   <= CMD_OFF;
                    end
                end
                WAIT_PIX: begin
                    if (pixValid && pixReady) begin
                        pixReady <= 1'b0;
                        dataOut  <= pix_ext;
                        rs       <= 1'b0;
                        tcnt     <= '0;
                        state    <= DATA;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    if (!xfer_last) begin
                        tcnt   <= tcnt + 1'b1;
                        dataEn <= (tcnt < T_PULSE);
                    end else begin
                        tcnt   <= '0;
                        dataEn <= 1'b0;
                        case (state)
                            CMD_OFF: begin
                                dataOut <= C_DIR;
                                state   <= CMD_DIR;
                            end
                            CMD_DIR: begin
                                dataOut <= C_ADDR;
                                state   <= CMD_ADDR;
                            end
                            CMD_ADDR: begin
                                pixReady <= 1'b1;
                                state    <= WAIT_PIX;
                            end
                            DATA: begin
                                pix_cnt <= pix_cnt + 7'd1;
                                if (pix_cnt + 7'd1 < N_PIX) begin
                                    pixReady <= 1'b1;
                                    state    <= WAIT_PIX;
                                end else begin
                                    dataOut <= C_ON;
                                    rs      <= 1'b1;
                                    state   <= CMD_ON;
                                end
                            end
                            CMD_ON: begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                pix_cnt <= '0;
                                state   <= FIN;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule
